// File: rtl/sp_wb8_wb32_bridge.sv
// Byte-wide Wishbone responder onto a 32-bit word port, with a one-word read buffer.
// Big-endian spec bit i of a W-bit bus is bit [W-1-i] here, so lane 0 is [31:24].
module sp_wb8_wb32_bridge #(
    parameter logic [7:0] ADDR_HI     = 8'h00,
    parameter bit         READ_BUFFER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] s_adr_i,
    input  logic [7:0]  s_dat_i,
    output logic [7:0]  s_dat_o,
    input  logic        s_we_i,
    input  logic        s_sel_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic        s_ack_o,
    input  logic        inval_i,
    output logic [29:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        req;
    logic        hit;
    logic        start;
    logic        done;
    logic        abort;
    logic        hit_ack;
    logic [31:0] rbuf;
    logic [21:0] tag;
    logic        valid;
    logic [1:0]  lane_q;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] l,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (l)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] l);
        logic [3:0] s;
        case (l)
            2'd0:    s = 4'b1000;
            2'd1:    s = 4'b0100;
            2'd2:    s = 4'b0010;
            default: s = 4'b0001;
        endcase
        return s;
    endfunction

    assign req = s_cyc_i & s_stb_i;
    assign hit = READ_BUFFER && valid && (tag == s_adr_i[23:2]);

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        hit_ack  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!s_we_i && hit) begin
                        state_nx = ACK;
                        hit_ack  = 1'b1;
                    end else if (s_we_i && !s_sel_i) begin
                        state_nx = ACK;
                    end else begin
                        state_nx = MREQ;
                        start    = 1'b1;
                    end
                end
            end
            MREQ: begin
                // A dropped initiator cycle wins over a same-cycle master ack.
                if (!s_cyc_i) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (m_ack_i) begin
                    state_nx = ACK;
                    done     = 1'b1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_dat_o <= '0;
            s_ack_o <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            m_stb_o <= 1'b0;
            m_cyc_o <= 1'b0;
            rbuf    <= '0;
            tag     <= '0;
            valid   <= 1'b0;
            lane_q  <= '0;
        end else begin
            s_ack_o <= (state_nx == ACK);
            if (start) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_adr_o <= {ADDR_HI, s_adr_i[23:2]};
                m_dat_o <= {4{s_dat_i}};
                m_we_o  <= s_we_i;
                m_sel_o <= s_we_i ? lane_sel(s_adr_i[1:0]) : 4'b1111;
                lane_q  <= s_adr_i[1:0];
            end
            if (done || abort) begin
                m_cyc_o <= 1'b0;
                m_stb_o <= 1'b0;
                m_we_o  <= 1'b0;
                m_sel_o <= '0;
            end
            if (hit_ack) s_dat_o <= lane_byte(rbuf, s_adr_i[1:0]);
            if (done && !m_we_o) begin
                rbuf    <= m_dat_i;
                tag     <= m_adr_o[21:0];
                valid   <= 1'b1;
                s_dat_o <= lane_byte(m_dat_i, lane_q);
            end
            // Write-through keeps a buffered copy of the same word coherent.
            if (done && m_we_o && valid && (tag == m_adr_o[21:0]))
                rbuf <= lane_put(rbuf, lane_q, m_dat_o[31:24]);
            if (inval_i) valid <= 1'b0;
        end
    end

endmodule
